cmos_window_capture: RTL and testbench
======================================

# cmos_window_capture

Parametrised capture front-end for the parallel CMOS sensor path (MT9V034-class) in the camera-to-VGA pipeline. Sits between the sensor-clock input registers and the Bayer-to-RGB stage. Generalises the fixed-offset capture block with:
- a programmable crop window
- power-of-two decimation (mono or Bayer-quad aware)
- frame-aligned start/stop
- per-frame shadowing of window settings
- a frame counter

Its `oSYNC` drives the SDRAM write-FIFO load.

## Interface
Parameters:
- `DATA_W`, 10: sensor pixel width.
- `CNT_W`, 16: width of coordinate counters and window inputs.
- `FCNT_W`, 32: frame counter width.
- `BAYER`, 1: 1 means decimation keeps whole 2x2 quads; 0 means per-pixel decimation.

Ports (one clock; reset is asynchronous and active-low):
- `iCLK` in 1: sensor pixel clock; sole clock.
- `iRST_N` in 1: asynchronous active-low reset.
- `iDATA` in `DATA_W`: registered sensor pixel.
- `iFVAL` in 1: frame valid.
- `iLVAL` in 1: line valid.
- `iSTART` in 1: level/pulse request to begin capturing.
- `iEND` in 1: level/pulse request to stop after the current frame.
- `iX_START`, `iY_START` in `CNT_W`: window origin in sensor pixels.
- `iWIDTH`, `iHEIGHT` in `CNT_W`: window size in sensor pixels; 0 means empty window.
- `iDECIM` in 2: decimation log2 (0..2); value 3 is treated as 2.
- `oDATA` out `DATA_W`: captured pixel.
- `oDVAL` out 1: `oDATA` valid.
- `oX_Cont`, `oY_Cont` out `CNT_W`: output-space coordinates of `oDATA`.
- `oSYNC` out 1: one-cycle pulse at the start of each captured frame.
- `oFRAME_CNT` out `FCNT_W`: completed captured frames.
- `oACTIVE` out 1: high in ARMED, CAPTURE and STOPPING.

## Operation
- FSM states: IDLE, ARMED, CAPTURE, STOPPING.
  - IDLE, `iSTART`=1 and `iEND`=0 → ARMED.
  - ARMED, FVAL rising edge → CAPTURE. Assert `oSYNC` and load shadow registers.
  - CAPTURE, FVAL falling edge: increment `oFRAME_CNT`, stay in CAPTURE. The next FVAL rise pulses `oSYNC` and reloads the shadows.
  - CAPTURE, `iEND`=1 → STOPPING. If this coincides with an FVAL fall, go directly to IDLE and still count the frame.
  - STOPPING, FVAL falling edge → IDLE and increment `oFRAME_CNT`.
  - ARMED, `iEND`=1 → IDLE with no frame counted.
- `iSTART` and `iEND` asserted together: `iEND` wins.
- Edge detection uses a one-cycle delayed copy of `iFVAL`/`iLVAL`.
- Shadow registers: `iX_START`, `iY_START`, `iWIDTH`, `iHEIGHT` and `iDECIM` are sampled only at an FVAL rise that enters or continues CAPTURE. Mid-frame changes never alter the current frame.
- Sensor counters `sx` and `sy`:
  - `sx` increments per cycle with FVAL&LVAL and clears on LVAL fall.
  - `sy` increments on LVAL fall and clears on FVAL rise.
  - Both saturate at 2^`CNT_W`-1.
- In-window test: `sx`-X_START in [0, WIDTH) and `sy`-Y_START in [0, HEIGHT). Compare in `CNT_W`+1 bits so that underflow and X_START+WIDTH overflow are both rejected.
- Decimation keep test, with `dx` = `sx`-X_START, `dy` = `sy`-Y_START and D = `iDECIM`:
  - `BAYER`=0: keep when `dx` mod 2^D = 0 and `dy` mod 2^D = 0.
  - `BAYER`=1: keep when (`dx`>>1) mod 2^D = 0 and (`dy`>>1) mod 2^D = 0.
- `oDVAL` = state in {CAPTURE, STOPPING} & FVAL & LVAL & in-window & keep.
- Output coordinates:
  - `oX_Cont` counts kept pixels on the current row and clears on LVAL fall.
  - `oY_Cont` increments on LVAL fall only if the row emitted at least one pixel, and clears on FVAL rise.

## Timing
- Latency is 1 cycle: inputs at cycle n produce `oDATA`/`oDVAL`/`oX_Cont`/`oY_Cont` registered at n+1.
- `oSYNC` is high for exactly the cycle after the FVAL rise is seen.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - shadow registers 0;
  - edge-detect registers 0.
- Reset mid-frame: everything returns immediately to the reset values. Capture resumes only after a new `iSTART` and the next full FVAL rise; a partial frame is never emitted.
- Entering ARMED while FVAL is already high waits for the next rise.
- `oFRAME_CNT` wraps modulo 2^`FCNT_W`.

## Structure
- Shared package holds:
  - the FSM state enum;
  - the `DECIM_MAX` = 2 constant.
- One natural sub-module, `sync_edge_det`: registers FVAL/LVAL and produces rise/fall strobes.
- Window, decimation and FSM logic stay in the top.

## Test plan
- Start is frame-aligned:
  - Stimulus: `iSTART` mid-frame, 8x4 frames, window (0,0,8,4), D=0.
  - Response: no `oDVAL` until the next frame; then 32 pixels, `oSYNC` pulses once per frame, `oFRAME_CNT` increments 1,2,...
- Crop window:
  - Stimulus: 16x8 frame with ramp data `sx`+16·`sy`; window (4,2,6,3).
  - Response: 18 pixels, first `oDATA`=36, `oX_Cont` 0..5, `oY_Cont` 0..2.
- Bayer decimation:
  - Stimulus: `BAYER`=1, D=1, full 16x8 window.
  - Response: kept columns 0,1,4,5,8,9,12,13 on rows 0,1,4,5; 32 pixels; `oX_Cont` max 7.
- Stop request:
  - Stimulus: `iEND` during frame 3.
  - Response: frame 3 is completed, `oFRAME_CNT`=3, `oACTIVE` falls on its FVAL fall, no further `oDVAL`.
- Shadow registers:
  - Stimulus: change `iWIDTH` 8→4 mid-frame.
  - Response: the current frame still emits 8 pixels per row; the next frame emits 4.
- Edge cases:
  - Stimulus: `iRST_N` low mid-line with `iSTART` and `iEND` asserted together afterwards.
  - Response: all outputs 0, FSM stays IDLE.
  - Stimulus: window X_START+WIDTH overflows `CNT_W`.
  - Response: pixels beyond 2^`CNT_W`-1 are rejected.

Source files
------------

// File: rtl/cmos_window_capture_pkg.sv
// Shared types and constants for the CMOS window capture front-end.
// The FSM encoding, the decimation limit and the decimation clamp helper.
package cmos_window_capture_pkg;

  localparam int DECIM_MAX = 2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_CAPTURE  = 2'd2,
    S_STOPPING = 2'd3
  } state_e;

  // A request of 3 (or anything above the limit) decimates by the limit.
  function automatic logic [1:0] decim_clamp(input logic [1:0] d);
    return (d > 2'(DECIM_MAX)) ? 2'(DECIM_MAX) : d;
  endfunction

endpackage

// File: rtl/cmos_window_capture_if.sv
// Sensor-side pixel bus, window settings and captured-pixel outputs.
// The master side drives the sensor stream; the capture block is the slave.
interface cmos_window_capture_if #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16,
  parameter int FCNT_W = 32
);
  logic [DATA_W-1:0] iDATA;
  logic              iFVAL;
  logic              iLVAL;
  logic              iSTART;
  logic              iEND;
  logic [CNT_W-1:0]  iX_START;
  logic [CNT_W-1:0]  iY_START;
  logic [CNT_W-1:0]  iWIDTH;
  logic [CNT_W-1:0]  iHEIGHT;
  logic [1:0]        iDECIM;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic [CNT_W-1:0]  oX_Cont;
  logic [CNT_W-1:0]  oY_Cont;
  logic              oSYNC;
  logic [FCNT_W-1:0] oFRAME_CNT;
  logic              oACTIVE;

  modport master (
    output iDATA, iFVAL, iLVAL, iSTART, iEND,
    output iX_START, iY_START, iWIDTH, iHEIGHT, iDECIM,
    input  oDATA, oDVAL, oX_Cont, oY_Cont, oSYNC, oFRAME_CNT, oACTIVE
  );

  modport slave (
    input  iDATA, iFVAL, iLVAL, iSTART, iEND,
    input  iX_START, iY_START, iWIDTH, iHEIGHT, iDECIM,
    output oDATA, oDVAL, oX_Cont, oY_Cont, oSYNC, oFRAME_CNT, oACTIVE
  );
endinterface

// File: rtl/cmos_window_capture_sync_edge_det.sv
// Delays FVAL/LVAL by one cycle and derives the frame/line edge strobes.
// Strobes are combinational and valid in the cycle the new level is presented.
module sync_edge_det (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iFVAL,
  input  logic iLVAL,
  output logic fval_rise,
  output logic fval_fall,
  output logic lval_fall
);
  logic fval_d_reg;
  logic lval_d_reg;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fval_d_reg <= 1'b0;
      lval_d_reg <= 1'b0;
    end else begin
      fval_d_reg <= iFVAL;
      lval_d_reg <= iLVAL;
    end
  end

  assign fval_rise = iFVAL & ~fval_d_reg;
  assign fval_fall = ~iFVAL & fval_d_reg;
  assign lval_fall = ~iLVAL & lval_d_reg;
endmodule

// File: rtl/cmos_window_capture.sv
// Frame-aligned crop/decimate capture stage between the sensor input registers
// and the Bayer-to-RGB stage; window settings are shadowed at each frame start.
module cmos_window_capture
  import cmos_window_capture_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16,
  parameter int FCNT_W = 32,
  parameter bit BAYER  = 1'b1
) (
  input  logic iCLK,
  input  logic iRST_N,
  cmos_window_capture_if.slave bus
);
  localparam logic [1:0] ST_IDLE     = S_IDLE;
  localparam logic [1:0] ST_ARMED    = S_ARMED;
  localparam logic [1:0] ST_CAPTURE  = S_CAPTURE;
  localparam logic [1:0] ST_STOPPING = S_STOPPING;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic fval_rise, fval_fall, lval_fall;

  sync_edge_det u_edge (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iFVAL     (bus.iFVAL),
    .iLVAL     (bus.iLVAL),
    .fval_rise (fval_rise),
    .fval_fall (fval_fall),
    .lval_fall (lval_fall)
  );

  logic [1:0] state_reg, state_next;
  logic       load_shadow, count_frame;

  // iEND is tested ahead of every other transition so it always wins.
  always_comb begin
    state_next  = state_reg;
    load_shadow = 1'b0;
    count_frame = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.iSTART && !bus.iEND) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (bus.iEND) begin
          state_next = ST_IDLE;
        end else if (fval_rise) begin
          state_next  = ST_CAPTURE;
          load_shadow = 1'b1;
        end
      end
      ST_CAPTURE: begin
        load_shadow = fval_rise;
        count_frame = fval_fall;
        if (bus.iEND) state_next = fval_fall ? ST_IDLE : ST_STOPPING;
      end
      ST_STOPPING: begin
        if (fval_fall) begin
          state_next  = ST_IDLE;
          count_frame = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  logic [CNT_W-1:0] xs_reg, ys_reg, w_reg, h_reg;
  logic [1:0]       d_reg;
  logic [CNT_W-1:0] sx_reg, sy_reg;
  logic             pix;

  assign pix = bus.iFVAL & bus.iLVAL;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg <= ST_IDLE;
      xs_reg    <= '0;
      ys_reg    <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
      d_reg     <= '0;
      sx_reg    <= '0;
      sy_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (load_shadow) begin
        xs_reg <= bus.iX_START;
        ys_reg <= bus.iY_START;
        w_reg  <= bus.iWIDTH;
        h_reg  <= bus.iHEIGHT;
        d_reg  <= decim_clamp(bus.iDECIM);
      end
      if (lval_fall)                     sx_reg <= '0;
      else if (pix && sx_reg != CNT_MAX) sx_reg <= sx_reg + CNT_W'(1);
      if (fval_rise)                           sy_reg <= '0;
      else if (lval_fall && sy_reg != CNT_MAX) sy_reg <= sy_reg + CNT_W'(1);
    end
  end

  // One extra bit keeps coordinates left of / above the origin negative.
  logic [CNT_W:0] dx, dy;
  logic           in_win, keep, emit, capturing;

  assign dx     = {1'b0, sx_reg} - {1'b0, xs_reg};
  assign dy     = {1'b0, sy_reg} - {1'b0, ys_reg};
  assign in_win = !dx[CNT_W] && (dx[CNT_W-1:0] < w_reg) &&
                  !dy[CNT_W] && (dy[CNT_W-1:0] < h_reg);

  logic [DECIM_MAX-1:0] dec_mask, dx_lsb, dy_lsb;

  for (genvar gi = 0; gi < DECIM_MAX; gi++) begin : g_mask
    assign dec_mask[gi] = (d_reg > 2'(gi));
  end

  // Bayer mode decimates 2x2 quads, so the pair bit is ignored.
  if (BAYER) begin : g_bayer
    assign dx_lsb = dx[DECIM_MAX:1];
    assign dy_lsb = dy[DECIM_MAX:1];
  end else begin : g_mono
    assign dx_lsb = dx[DECIM_MAX-1:0];
    assign dy_lsb = dy[DECIM_MAX-1:0];
  end

  assign keep      = ((dx_lsb | dy_lsb) & dec_mask) == '0;
  assign capturing = (state_reg == ST_CAPTURE) || (state_reg == ST_STOPPING);
  assign emit      = capturing & pix & in_win & keep;

  logic [DATA_W-1:0] data_reg;
  logic              dval_reg, sync_reg, row_hit_reg;
  logic [CNT_W-1:0]  ox_cnt_reg, oy_cnt_reg, ox_out_reg, oy_out_reg;
  logic [FCNT_W-1:0] fcnt_reg;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      data_reg    <= '0;
      dval_reg    <= 1'b0;
      sync_reg    <= 1'b0;
      row_hit_reg <= 1'b0;
      ox_cnt_reg  <= '0;
      oy_cnt_reg  <= '0;
      ox_out_reg  <= '0;
      oy_out_reg  <= '0;
      fcnt_reg    <= '0;
    end else begin
      dval_reg <= emit;
      sync_reg <= load_shadow;
      if (emit) begin
        data_reg   <= bus.iDATA;
        ox_out_reg <= ox_cnt_reg;
        oy_out_reg <= oy_cnt_reg;
      end
      if (lval_fall) begin
        ox_cnt_reg  <= '0;
        row_hit_reg <= 1'b0;
      end else if (emit) begin
        ox_cnt_reg  <= ox_cnt_reg + CNT_W'(1);
        row_hit_reg <= 1'b1;
      end
      if (fval_rise)                       oy_cnt_reg <= '0;
      else if (lval_fall && row_hit_reg)   oy_cnt_reg <= oy_cnt_reg + CNT_W'(1);
      if (count_frame) fcnt_reg <= fcnt_reg + FCNT_W'(1);
    end
  end

  assign bus.oDATA      = data_reg;
  assign bus.oDVAL      = dval_reg;
  assign bus.oX_Cont    = ox_out_reg;
  assign bus.oY_Cont    = oy_out_reg;
  assign bus.oSYNC      = sync_reg;
  assign bus.oFRAME_CNT = fcnt_reg;
  assign bus.oACTIVE    = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_cmos_window_capture.sv
// Scoreboard bench: a mono and a Bayer instance share one sensor stream;
// expected pixels are queued before each frame and popped by a monitor.
module tb_cmos_window_capture;
  localparam int DW = 10;
  localparam int CW = 8;
  localparam int FW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fval = 1'b0, lval = 1'b0, start_m = 1'b0, start_b = 1'b0, end_sig = 1'b0;
  logic [DW-1:0] pdata = '0;
  logic [CW-1:0] xs = '0, ys = '0, wd = '0, ht = '0;
  logic [1:0]    dec = '0;

  pix_t exp_m[$], exp_b[$], obs_m[$], obs_b[$];
  int   n_cmp = 0, n_bad = 0, sync_m = 0, sync_b = 0;

  always #5 clk = ~clk;

  cmos_window_capture_if #(.DATA_W(DW), .CNT_W(CW), .FCNT_W(FW)) if_m ();
  cmos_window_capture_if #(.DATA_W(DW), .CNT_W(CW), .FCNT_W(FW)) if_b ();

  assign if_m.iDATA = pdata;   assign if_b.iDATA = pdata;
  assign if_m.iFVAL = fval;    assign if_b.iFVAL = fval;
  assign if_m.iLVAL = lval;    assign if_b.iLVAL = lval;
  assign if_m.iSTART = start_m; assign if_b.iSTART = start_b;
  assign if_m.iEND = end_sig;  assign if_b.iEND = end_sig;
  assign if_m.iX_START = xs;   assign if_b.iX_START = xs;
  assign if_m.iY_START = ys;   assign if_b.iY_START = ys;
  assign if_m.iWIDTH = wd;     assign if_b.iWIDTH = wd;
  assign if_m.iHEIGHT = ht;    assign if_b.iHEIGHT = ht;
  assign if_m.iDECIM = dec;    assign if_b.iDECIM = dec;

  cmos_window_capture #(.DATA_W(DW), .CNT_W(CW), .FCNT_W(FW), .BAYER(1'b0)) u_mono (
    .iCLK(clk), .iRST_N(rst_n), .bus(if_m));
  cmos_window_capture #(.DATA_W(DW), .CNT_W(CW), .FCNT_W(FW), .BAYER(1'b1)) u_bayer (
    .iCLK(clk), .iRST_N(rst_n), .bus(if_b));

  // Monitor: every presented pixel is logged and checked against the queue head.
  always @(negedge clk) begin
    pix_t g, e;
    if (if_m.oDVAL) begin
      g = '{if_m.oDATA, if_m.oX_Cont, if_m.oY_Cont};
      obs_m.push_back(g);
      n_cmp++;
      if (exp_m.size() == 0) begin
        n_bad++;
        $display("FAIL mono_pixel: got d=%0d x=%0d y=%0d, required no pixel", g.d, g.x, g.y);
      end else begin
        e = exp_m.pop_front();
        if (g != e) begin
          n_bad++;
          $display("FAIL mono_pixel: got d=%0d x=%0d y=%0d, required d=%0d x=%0d y=%0d",
                   g.d, g.x, g.y, e.d, e.x, e.y);
        end
      end
    end
    if (if_b.oDVAL) begin
      g = '{if_b.oDATA, if_b.oX_Cont, if_b.oY_Cont};
      obs_b.push_back(g);
      n_cmp++;
      if (exp_b.size() == 0) begin
        n_bad++;
        $display("FAIL bayer_pixel: got d=%0d x=%0d y=%0d, required no pixel", g.d, g.x, g.y);
      end else begin
        e = exp_b.pop_front();
        if (g != e) begin
          n_bad++;
          $display("FAIL bayer_pixel: got d=%0d x=%0d y=%0d, required d=%0d x=%0d y=%0d",
                   g.d, g.x, g.y, e.d, e.x, e.y);
        end
      end
    end
    if (if_m.oSYNC) sync_m++;
    if (if_b.oSYNC) sync_b++;
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic cyc(input logic f, input logic l, input int d);
    @(negedge clk);
    #1;
    fval  = f;
    lval  = l;
    pdata = DW'(d);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #1;
    rst_n = 1'b0; start_m = 1'b0; start_b = 1'b0; end_sig = 1'b0;
    fval = 1'b0; lval = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Ramp data sx + 16*sy; act selects a mid-frame event.
  task automatic send_frame(input int w, input int h, input int act);
    cyc(1, 0, 0); cyc(1, 0, 0);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        cyc(1, 1, (c + 16 * r) % 1024);
        if (act == 1 && r == 1 && c == 0) start_m = 1'b1;
        if (act == 2 && r == 1 && c == 0) wd = 8'd4;
        if (act == 3 && r == 1 && c == 0) begin end_sig = 1'b1; start_m = 1'b0; end
        if (act == 4 && r == 0 && c == 3) begin rst_n = 1'b0; start_m = 1'b1; end_sig = 1'b1; end
        if (act == 4 && r == 0 && c == 5) rst_n = 1'b1;
      end
      repeat (3) cyc(1, 0, 0);
    end
    repeat (4) cyc(0, 0, 0);
  endtask

  // Expected stream for one full frame from the current window settings.
  task automatic push_exp(input bit to_b, input int fw, input int fh);
    int yo = 0;
    for (int sy = 0; sy < fh; sy++) begin
      int xo = 0;
      for (int sx = 0; sx < fw; sx++) begin
        int dx = sx - int'(xs);
        int dy = sy - int'(ys);
        int kx = to_b ? (dx >> 1) : dx;
        int ky = to_b ? (dy >> 1) : dy;
        int m  = 1 << dec;
        if (dx >= 0 && dx < int'(wd) && dy >= 0 && dy < int'(ht) &&
            (kx % m) == 0 && (ky % m) == 0) begin
          pix_t p = '{DW'((sx + 16 * sy) % 1024), CW'(xo), CW'(yo)};
          if (to_b) exp_b.push_back(p); else exp_m.push_back(p);
          xo++;
        end
      end
      if (xo != 0) yo++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bm, bb, sm, mx;

    reset_dut();
    @(negedge clk);
    chk("reset_dval", if_m.oDVAL, 0);
    chk("reset_data", if_m.oDATA, 0);
    chk("reset_sync", if_m.oSYNC, 0);
    chk("reset_fcnt", if_m.oFRAME_CNT, 0);
    chk("reset_active", if_m.oACTIVE, 0);

    // Start requested mid-frame: that frame is skipped.
    xs = 0; ys = 0; wd = 8; ht = 4; dec = 0;
    bm = obs_m.size(); sm = sync_m;
    send_frame(8, 4, 1);
    chk("start_no_early_pixels", obs_m.size() - bm, 0);
    chk("start_armed_active", if_m.oACTIVE, 1);
    push_exp(0, 8, 4); send_frame(8, 4, 0);
    chk("start_fcnt1", if_m.oFRAME_CNT, 1);
    push_exp(0, 8, 4); send_frame(8, 4, 0);
    chk("start_fcnt2", if_m.oFRAME_CNT, 2);
    chk("start_sync_pulses", sync_m - sm, 2);
    chk("start_pixels", obs_m.size() - bm, 64);
    chk("start_queue_left", exp_m.size(), 0);

    // Crop window (4,2,6,3) on a 16x8 ramp frame.
    reset_dut();
    xs = 4; ys = 2; wd = 6; ht = 3; dec = 0; start_m = 1'b1;
    bm = obs_m.size();
    push_exp(0, 16, 8); send_frame(16, 8, 0);
    chk("crop_pixels", obs_m.size() - bm, 18);
    if (obs_m.size() > bm) begin
      chk("crop_first_data", obs_m[bm].d, 36);
      chk("crop_last_x", obs_m[obs_m.size() - 1].x, 5);
      chk("crop_last_y", obs_m[obs_m.size() - 1].y, 2);
    end
    chk("crop_queue_left", exp_m.size(), 0);

    // Bayer quad decimation, D=1, full 16x8 window.
    reset_dut();
    xs = 0; ys = 0; wd = 16; ht = 8; dec = 1; start_b = 1'b1;
    bm = obs_m.size(); bb = obs_b.size();
    push_exp(1, 16, 8); send_frame(16, 8, 0);
    chk("bayer_pixels", obs_b.size() - bb, 32);
    mx = 0;
    for (int i = bb; i < obs_b.size(); i++) if (int'(obs_b[i].x) > mx) mx = int'(obs_b[i].x);
    chk("bayer_max_x", mx, 7);
    chk("bayer_mono_idle", obs_m.size() - bm, 0);
    chk("bayer_queue_left", exp_b.size(), 0);

    // Stop request during frame 3.
    reset_dut();
    xs = 0; ys = 0; wd = 8; ht = 4; dec = 0; start_m = 1'b1;
    bm = obs_m.size();
    push_exp(0, 8, 4); send_frame(8, 4, 0);
    push_exp(0, 8, 4); send_frame(8, 4, 0);
    push_exp(0, 8, 4); send_frame(8, 4, 3);
    chk("stop_fcnt", if_m.oFRAME_CNT, 3);
    chk("stop_active", if_m.oACTIVE, 0);
    send_frame(8, 4, 0);
    chk("stop_pixels", obs_m.size() - bm, 96);
    chk("stop_fcnt_hold", if_m.oFRAME_CNT, 3);
    chk("stop_queue_left", exp_m.size(), 0);

    // Width change mid-frame takes effect on the next frame only.
    reset_dut();
    xs = 0; ys = 0; wd = 8; ht = 4; dec = 0; start_m = 1'b1;
    bm = obs_m.size();
    push_exp(0, 8, 4); send_frame(8, 4, 2);
    chk("shadow_frame_a", obs_m.size() - bm, 32);
    push_exp(0, 8, 4); send_frame(8, 4, 0);
    chk("shadow_frame_b", obs_m.size() - bm, 48);
    chk("shadow_queue_left", exp_m.size(), 0);

    // Reset mid-line, then iSTART and iEND together.
    reset_dut();
    xs = 0; ys = 0; wd = 8; ht = 4; dec = 0; start_m = 1'b1;
    bm = obs_m.size(); sm = sync_m;
    exp_m.push_back('{DW'(0), CW'(0), CW'(0)});
    exp_m.push_back('{DW'(1), CW'(1), CW'(0)});
    exp_m.push_back('{DW'(2), CW'(2), CW'(0)});
    send_frame(8, 4, 4);
    send_frame(8, 4, 0);
    chk("rst_pixels", obs_m.size() - bm, 3);
    chk("rst_dval", if_m.oDVAL, 0);
    chk("rst_data", if_m.oDATA, 0);
    chk("rst_x", if_m.oX_Cont, 0);
    chk("rst_y", if_m.oY_Cont, 0);
    chk("rst_fcnt", if_m.oFRAME_CNT, 0);
    chk("rst_active", if_m.oACTIVE, 0);
    chk("rst_sync_pulses", sync_m - sm, 1);
    chk("rst_queue_left", exp_m.size(), 0);

    // Window X_START+WIDTH past 2^CNT_W-1 on a 256-wide frame.
    reset_dut();
    xs = 250; ys = 0; wd = 20; ht = 2; dec = 0; start_m = 1'b1;
    bm = obs_m.size();
    push_exp(0, 256, 2); send_frame(256, 2, 0);
    chk("ovf_pixels", obs_m.size() - bm, 12);
    chk("ovf_queue_left", exp_m.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
